// File: rtl/trace_pkg.sv
// Shared types and helpers for the commit trace buffer: record kinds,
// the default record layout and the saturating drop counter update.
package trace_pkg;

  localparam int DROP_CNT_W   = 8;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 9;
  localparam int TRACE_TS_W   = 16;

  // Record kind; 2'b11 is reserved and never produced.
  typedef enum logic [1:0] {
    REG   = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } trace_kind_e;

  // Record layout at the default widths, most significant field first.
  typedef struct packed {
    trace_kind_e              kind;
    logic [TRACE_ADDR_W-1:0]  idx;
    logic [TRACE_DATA_W-1:0]  data;
    logic [TRACE_TS_W-1:0]    ts;
  } trace_entry_t;

  // Adds 0..2 drops to the counter, clamping at all-ones.
  function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
    input logic [DROP_CNT_W-1:0] cnt,
    input logic [1:0]            inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + (DROP_CNT_W+1)'(inc);
    if (sum[DROP_CNT_W]) begin
      return {DROP_CNT_W{1'b1}};
    end else begin
      return sum[DROP_CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Record FIFO with two ordered write ports and one read port.
// Port 0 is written at the tail, port 1 right behind it; port 1 is only
// honoured together with port 0. The head is read combinationally from
// registered storage. The caller guarantees it never writes past DEPTH.
module trace_fifo_2w1r
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 59
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr0_en,
  input  logic [WIDTH-1:0]           wr0_data,
  input  logic                       wr1_en,
  input  logic [WIDTH-1:0]           wr1_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             wr1_act_s;
  logic             rd_act_s;
  logic [1:0]       n_wr_s;
  logic [PTR_W-1:0] wptr_p1_s;

  // Decode how many slots are written and whether the head is consumed.
  always_comb begin
    wr1_act_s = wr0_en && wr1_en;
    rd_act_s  = rd_en && (count_q != CNT_W'(0));
    n_wr_s    = {1'b0, wr0_en} + {1'b0, wr1_act_s};
    wptr_p1_s = wptr_q + PTR_W'(1);
  end

  // Next storage, pointer and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    mem_d = mem_q;
    if (wr0_en) begin
      mem_d[wptr_q] = wr0_data;
    end else begin
      mem_d[wptr_q] = mem_q[wptr_q];
    end
    if (wr1_act_s) begin
      mem_d[wptr_p1_s] = wr1_data;
    end else begin
      mem_d[wptr_p1_s] = mem_q[wptr_p1_s];
    end
    wptr_d = wptr_q + PTR_W'(n_wr_s);
    if (rd_act_s) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    count_d = count_q + CNT_W'(n_wr_s) - CNT_W'(rd_act_s);
  end

  // Record storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers and occupancy; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= PTR_W'(0);
      rptr_q  <= PTR_W'(0);
      count_q <= CNT_W'(0);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Head record and occupancy are exposed straight from registers.
  always_comb begin
    rd_data = mem_q[rptr_q];
    count   = count_q;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Turns the core's write-back and data-memory debug strobes into
// timestamped trace records, queues them and drains one per cycle over
// valid/ready. Events that do not fit are counted as drops.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int TS_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           trace_en,
  input  logic [4:0]                     reg_num,
  input  logic [DATA_W-1:0]              reg_data,
  input  logic                           reg_write_sig,
  input  logic                           wr,
  input  logic                           rd,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic [DATA_W-1:0]              rd_data,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [2+ADDR_W+DATA_W+TS_W-1:0] trace_entry,
  output logic [DROP_CNT_W-1:0]          drop_cnt,
  output logic                           overflow,
  input  logic                           drop_clr
);

  localparam int ENTRY_W = 2 + ADDR_W + DATA_W + TS_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]       ts_q, ts_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  overflow_q, overflow_d;

  logic                  reg_ev_s;
  logic                  st_ev_s;
  logic                  ld_ev_s;
  logic                  mem_ev_s;
  trace_kind_e           mem_kind_s;
  logic [ADDR_W-1:0]     mem_idx_s;
  logic [DATA_W-1:0]     mem_data_s;
  logic [ENTRY_W-1:0]    reg_rec_s;
  logic [ENTRY_W-1:0]    mem_rec_s;

  logic [CNT_W-1:0]      fifo_count_s;
  logic [CNT_W-1:0]      free_s;
  logic [1:0]            n_ev_s;
  logic [1:0]            n_push_s;
  logic [1:0]            n_drop_s;
  logic                  wr0_en_s;
  logic [ENTRY_W-1:0]    wr0_data_s;
  logic                  wr1_en_s;
  logic [ENTRY_W-1:0]    wr1_data_s;
  logic                  pop_s;
  logic [ENTRY_W-1:0]    head_s;

  // Qualify this cycle's events; a store masks a simultaneous load.
  always_comb begin
    reg_ev_s = trace_en && reg_write_sig && (reg_num != 5'd0);
    st_ev_s  = trace_en && wr;
    ld_ev_s  = trace_en && rd && !wr;
    mem_ev_s = st_ev_s || ld_ev_s;
    if (st_ev_s) begin
      mem_kind_s = STORE;
      mem_data_s = wr_data;
    end else begin
      mem_kind_s = LOAD;
      mem_data_s = rd_data;
    end
    mem_idx_s = addr;
  end

  // Build both candidate records; they share the current timestamp.
  always_comb begin
    reg_rec_s = {REG, ADDR_W'(reg_num), reg_data, ts_q};
    mem_rec_s = {mem_kind_s, mem_idx_s, mem_data_s, ts_q};
  end

  // Space check against occupancy at the start of the cycle; a pop in the
  // same cycle does not free a slot. The reg event always goes first.
  always_comb begin
    free_s = CNT_W'(DEPTH) - fifo_count_s;
    n_ev_s = {1'b0, reg_ev_s} + {1'b0, mem_ev_s};
    if (free_s >= CNT_W'(2)) begin
      n_push_s = n_ev_s;
    end else if (free_s == CNT_W'(1)) begin
      n_push_s = (n_ev_s != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      n_push_s = 2'd0;
    end
    n_drop_s = n_ev_s - n_push_s;
  end

  // Map accepted records onto the ordered FIFO write ports.
  always_comb begin
    wr0_en_s = (n_push_s != 2'd0);
    wr1_en_s = (n_push_s == 2'd2);
    if (reg_ev_s) begin
      wr0_data_s = reg_rec_s;
    end else begin
      wr0_data_s = mem_rec_s;
    end
    wr1_data_s = mem_rec_s;
  end

  // Next timestamp and drop bookkeeping; a clear still counts this cycle.
  always_comb begin
    ts_d = ts_q + TS_W'(1);
    if (drop_clr) begin
      drop_cnt_d = DROP_CNT_W'(n_drop_s);
      overflow_d = (n_drop_s != 2'd0);
    end else begin
      drop_cnt_d = sat_add_drop(drop_cnt_q, n_drop_s);
      overflow_d = overflow_q || (n_drop_s != 2'd0);
    end
  end

  // Timestamp and drop state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= TS_W'(0);
      drop_cnt_q <= DROP_CNT_W'(0);
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo_2w1r #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (wr0_en_s),
    .wr0_data (wr0_data_s),
    .wr1_en   (wr1_en_s),
    .wr1_data (wr1_data_s),
    .rd_en    (pop_s),
    .rd_data  (head_s),
    .count    (fifo_count_s)
  );

  // Drain side; the entry reads as zero whenever nothing is queued.
  always_comb begin
    trace_valid = (fifo_count_s != CNT_W'(0));
    pop_s       = trace_valid && trace_ready;
    if (trace_valid) begin
      trace_entry = head_s;
    end else begin
      trace_entry = {ENTRY_W{1'b0}};
    end
    drop_cnt = drop_cnt_q;
    overflow = overflow_q;
  end

endmodule
